// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, immediate formats and bubble encoding shared by the decode stage
package decode_pkg;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_IMM    = 7'd19;
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [31:0] NOP_DEFAULT = 32'h00000013;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
endpackage

// File: rtl/imm_gen_x.sv
// imm_gen_x: sign-extended immediate of the selected format
module imm_gen_x
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm
);
  logic [31:0] raw;
  always_comb begin
    raw = imm_type == IMM_S ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
          imm_type == IMM_B ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} :
          imm_type == IMM_U ? {ir[31:12], 12'b0} :
          imm_type == IMM_J ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0} :
                              {{20{ir[31]}}, ir[31:20]};
  end
  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/decode_stage_reg.sv
// decode_stage_reg: registered decode with operand forwarding, load-use stall and ID/EX handshake
module decode_stage_reg
  import decode_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
  parameter logic        FWD_EN    = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir2_output,
  input  logic [XLEN-1:0]  pc2_output,
  input  logic [XLEN-1:0]  r1_value,
  input  logic [XLEN-1:0]  r2_value,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  z5_output,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      ir3,
  output logic [XLEN-1:0]  pc3,
  output logic [XLEN-1:0]  x3,
  output logic [XLEN-1:0]  y3,
  output logic [XLEN-1:0]  md3,
  output logic [XLEN-1:0]  br_target,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic [XLEN-1:0] rs1f, rs2f, imm, imm_i, x_n, y_n, bt_n;
  logic use_rs1, use_rs2, haz, adv, known;
  imm_type_t itype;
  assign op  = ir2_output[6:0];
  assign rs1 = ir2_output[19:15];
  assign rs2 = ir2_output[24:20];
  assign rs1f = rs1 == 5'd0 ? '0 : (FWD_EN && wb_valid && wb_rd == rs1) ? z5_output : r1_value;
  assign rs2f = rs2 == 5'd0 ? '0 : (FWD_EN && wb_valid && wb_rd == rs2) ? z5_output : r2_value;
  assign use_rs1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  assign use_rs2 = op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
  assign haz = in_valid && ex_load && ex_rd != 5'd0 &&
               ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
  assign adv = !out_valid || out_ready;
  assign in_ready = flush || (adv && !haz);
  assign known = op inside {OPC_OP, OPC_IMM, OPC_LOAD, OPC_JALR, OPC_AUIPC,
                            OPC_LUI, OPC_STORE, OPC_BRANCH, OPC_JAL};
  always_comb begin
    itype = op == OPC_STORE ? IMM_S :
            op == OPC_BRANCH ? IMM_B :
            (op == OPC_LUI || op == OPC_AUIPC) ? IMM_U :
            op == OPC_JAL ? IMM_J : IMM_I;
  end
  imm_gen_x #(.XLEN(XLEN)) u_imm (.ir(ir2_output), .imm_type(itype), .imm(imm));
  // I-immediate is also the default target base, independent of the format selected above
  assign imm_i = XLEN'($signed(ir2_output[31:20]));
  always_comb begin
    x_n = op == OPC_LUI ? '0 :
          (op == OPC_JALR || op == OPC_AUIPC || op == OPC_JAL) ? pc2_output : rs1f;
    y_n = (op == OPC_JALR || op == OPC_JAL) ? XLEN'(4) :
          (op == OPC_IMM || op == OPC_LOAD || op == OPC_STORE ||
           op == OPC_AUIPC || op == OPC_LUI) ? imm : rs2f;
    bt_n = op == OPC_JALR ? (rs1f + imm_i) & ~XLEN'(1) :
           (op == OPC_BRANCH || op == OPC_JAL) ? pc2_output + imm : pc2_output + imm_i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ir3       <= NOP_INSTR;
      pc3       <= '0;
      x3        <= '0;
      y3        <= '0;
      md3       <= '0;
      br_target <= '0;
      illegal   <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ir3       <= NOP_INSTR;
    end else if (adv) begin
      if (haz || !in_valid) begin
        out_valid <= 1'b0;
        ir3       <= NOP_INSTR;
        if (haz && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        out_valid <= 1'b1;
        ir3       <= ir2_output;
        pc3       <= pc2_output;
        x3        <= x_n;
        y3        <= y_n;
        md3       <= rs2f;
        br_target <= bt_n;
        illegal   <= !known;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage_reg.sv
// tb_decode_stage_reg: directed and random checks of the decode stage against an opcode-level model
module tb_decode_stage_reg;
  logic clk = 1'b0, reset = 1'b0, flush, in_valid, wb_valid, ex_load, out_ready;
  logic [31:0] ir2_output, pc2_output, r1_value, r2_value, z5_output;
  logic [4:0] wb_rd, ex_rd;
  logic in_ready, out_valid, illegal, in_ready_b, out_valid_b, illegal_b;
  logic [31:0] ir3, pc3, x3, y3, md3, br_target;
  logic [31:0] ir3_b, pc3_b, x3_b, y3_b, md3_b, br_target_b;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt_b;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  decode_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ir2_output(ir2_output), .pc2_output(pc2_output), .r1_value(r1_value), .r2_value(r2_value),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .z5_output(z5_output), .ex_load(ex_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .ir3(ir3), .pc3(pc3), .x3(x3), .y3(y3),
    .md3(md3), .br_target(br_target), .illegal(illegal), .stall_cnt(stall_cnt));

  decode_stage_reg #(.FWD_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .ir2_output(ir2_output), .pc2_output(pc2_output), .r1_value(r1_value), .r2_value(r2_value),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .z5_output(z5_output), .ex_load(ex_load), .ex_rd(ex_rd),
    .out_valid(out_valid_b), .out_ready(out_ready), .ir3(ir3_b), .pc3(pc3_b), .x3(x3_b), .y3(y3_b),
    .md3(md3_b), .br_target(br_target_b), .illegal(illegal_b), .stall_cnt(stall_cnt_b));

  typedef struct packed {
    logic v; logic [31:0] ir, pc, x, y, md, bt; logic ill; logic [15:0] cnt;
  } st_t;
  st_t m [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input int rs, input logic [31:0] rv, input bit fwd);
    if (rs == 0) return 32'd0;
    if (fwd && wb_valid && int'(wb_rd) == rs) return z5_output;
    return rv;
  endfunction

  function automatic bit hazard();
    int op = int'(ir2_output[6:0]);
    int a = int'(ir2_output[19:15]), b = int'(ir2_output[24:20]);
    bit u1 = !(op == 55 || op == 23 || op == 111);
    bit u2 = (op == 51 || op == 35 || op == 99);
    return in_valid && ex_load && ex_rd != 0 && ((u1 && a == int'(ex_rd)) || (u2 && b == int'(ex_rd)));
  endfunction

  function automatic st_t dec(input bit fwd, input st_t prev);
    st_t s;
    int op = int'(ir2_output[6:0]);
    logic [31:0] a, b, pc, ii, si, bi, ji, ui;
    a  = opnd(int'(ir2_output[19:15]), r1_value, fwd);
    b  = opnd(int'(ir2_output[24:20]), r2_value, fwd);
    pc = pc2_output;
    ii = 32'(int'($signed(ir2_output[31:20])));
    si = 32'(int'($signed({ir2_output[31:25], ir2_output[11:7]})));
    bi = 32'(int'($signed({ir2_output[31], ir2_output[7], ir2_output[30:25], ir2_output[11:8], 1'b0})));
    ji = 32'(int'($signed({ir2_output[31], ir2_output[19:12], ir2_output[20], ir2_output[30:21], 1'b0})));
    ui = 32'(ir2_output[31:12]) * 32'd4096;
    s = prev;
    s.v = 1'b1; s.ir = ir2_output; s.pc = pc; s.md = b; s.bt = pc + ii; s.ill = 1'b0;
    case (op)
      51:     begin s.x = a;  s.y = b; end
      19, 3:  begin s.x = a;  s.y = ii; end
      103:    begin s.x = pc; s.y = 32'd4; s.bt = (a + ii) & 32'hFFFFFFFE; end
      23:     begin s.x = pc; s.y = ui; end
      55:     begin s.x = 0;  s.y = ui; end
      35:     begin s.x = a;  s.y = si; end
      99:     begin s.x = a;  s.y = b; s.bt = pc + bi; end
      111:    begin s.x = pc; s.y = 32'd4; s.bt = pc + ji; end
      default: begin s.x = a; s.y = b; s.ill = 1'b1; end
    endcase
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) m[k] = '{v: 1'b0, ir: 32'h13, default: '0};
      else if (flush) begin m[k].v = 1'b0; m[k].ir = 32'h13; end
      else if (!m[k].v || out_ready) begin
        if (hazard()) begin
          m[k].v = 1'b0; m[k].ir = 32'h13;
          if (m[k].cnt < (k == 0 ? 16'hFFFF : 16'd3)) m[k].cnt = m[k].cnt + 16'd1;
        end else if (in_valid) m[k] = dec(k == 0, m[k]);
        else begin m[k].v = 1'b0; m[k].ir = 32'h13; end
      end
    end
  end

  function automatic logic exp_ready(input st_t s);
    return flush || ((!s.v || out_ready) && !hazard());
  endfunction

  always @(negedge clk) begin
    chk("valid", {31'b0, out_valid}, {31'b0, m[0].v});
    chk("ready", {31'b0, in_ready}, {31'b0, exp_ready(m[0])});
    chk("ir3", ir3, m[0].ir);
    chk("pc3", pc3, m[0].pc);
    chk("x3", x3, m[0].x);
    chk("y3", y3, m[0].y);
    chk("md3", md3, m[0].md);
    chk("br_target", br_target, m[0].bt);
    chk("illegal", {31'b0, illegal}, {31'b0, m[0].ill});
    chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, m[0].cnt});
    chk("valid_b", {31'b0, out_valid_b}, {31'b0, m[1].v});
    chk("ready_b", {31'b0, in_ready_b}, {31'b0, exp_ready(m[1])});
    chk("ir3_b", ir3_b, m[1].ir);
    chk("x3_b", x3_b, m[1].x);
    chk("y3_b", y3_b, m[1].y);
    chk("md3_b", md3_b, m[1].md);
    chk("br_target_b", br_target_b, m[1].bt);
    chk("illegal_b", {31'b0, illegal_b}, {31'b0, m[1].ill});
    chk("stall_cnt_b", {30'b0, stall_cnt_b}, {16'b0, m[1].cnt});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [6:0] OPS [10] = '{7'd51, 7'd19, 7'd3, 7'd103, 7'd23, 7'd55, 7'd35, 7'd99, 7'd111, 7'd0};

  initial begin
    flush = 0; in_valid = 0; wb_valid = 0; ex_load = 0; out_ready = 1;
    ir2_output = 32'h13; pc2_output = 0; r1_value = 0; r2_value = 0;
    z5_output = 0; wb_rd = 0; ex_rd = 0;
    #2 reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    ir2_output = 32'hFFF08293; pc2_output = 32'h40; r1_value = 10; in_valid = 1;
    tick();
    chk("addi_x3", x3, 32'd10);
    chk("addi_y3", y3, 32'hFFFFFFFF);
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    ir2_output = 32'h002081B3; r1_value = 5; r2_value = 7; wb_valid = 1; wb_rd = 2; z5_output = 99;
    tick();
    chk("fwd_y3", y3, 32'd99);
    chk("nofwd_y3", y3_b, 32'd7);
    chk("fwd_x3", x3, 32'd5);
    ir2_output = 32'h002001B3; wb_rd = 0; r1_value = 55;
    tick();
    chk("rs0_x3", x3, 32'd0);
    chk("rs0_y3", y3, 32'd7);
    wb_valid = 0;
    ir2_output = 32'hFFF08293; r1_value = 10; ex_load = 1; ex_rd = 1;
    #1 chk("luse_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("luse_valid", {31'b0, out_valid}, 32'd0);
    chk("luse_ir3", ir3, 32'h13);
    chk("luse_cnt", {16'b0, stall_cnt}, 32'd1);
    ex_load = 0;
    tick();
    chk("issue_valid", {31'b0, out_valid}, 32'd1);
    chk("issue_ir3", ir3, 32'hFFF08293);
    ir2_output = 32'hFE208CE3; pc2_output = 32'h100;
    tick();
    chk("beq_target", br_target, 32'hF8);
    ir2_output = 32'h008000EF; pc2_output = 32'hFFFFFFFC;
    tick();
    chk("jal_target", br_target, 32'h4);
    chk("jal_y3", y3, 32'h4);
    out_ready = 0; ir2_output = 32'hFFF08293; pc2_output = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ir3", ir3, 32'h008000EF);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    flush = 1;
    #1 chk("flush_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ir3", ir3, 32'h13);
    flush = 0; out_ready = 1; ex_load = 1; ex_rd = 1;
    tick();
    tick();
    chk("stall3_cnt", {16'b0, stall_cnt}, 32'd3);
    #1 reset = 1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ir3", ir3, 32'h13);
    chk("rst_cnt", {16'b0, stall_cnt}, 32'd0);
    tick();
    reset = 0; ex_load = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      ir2_output = $urandom;
      ir2_output[6:0] = OPS[$urandom_range(0, 9)];
      ir2_output[19:15] = 5'($urandom_range(0, 3));
      ir2_output[24:20] = 5'($urandom_range(0, 3));
      pc2_output = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15)) : $urandom;
      r1_value = $urandom; r2_value = $urandom; z5_output = $urandom;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      ex_load = $urandom_range(0, 2) == 0;
      ex_rd = 5'($urandom_range(0, 3));
      wb_valid = $urandom_range(0, 1) == 1;
      wb_rd = 5'($urandom_range(0, 3));
    end
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_reg.md
Name: decode_stage_reg

Overview:
- Parametrised, registered successor to the combinational decode stage; it owns the ID/EX pipeline register set (ir3, pc3, x3, y3, md3, branch target).
- Decodes the instruction internally, generates the immediate and selects operands, replacing the external mux selects.
- Forwards writeback data, detects load-use hazards, and applies a valid/ready handshake with flush.
- Sits between the IF/ID register and the execute stage.

Parameters:
- XLEN, 32, datapath width of pc, operands and results (32 or 64; the instruction is always 32 bits).
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) loaded into ir3.
- FWD_EN, 1, when 1 forward z5 on register match; when 0 use r1/r2_value unmodified.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  kill the instruction being accepted and the output register.
- in_valid  in  1  ir2/pc2 valid.
- in_ready  out  1  stage accepts ir2/pc2 this cycle.
- ir2_output  in  32  instruction from IF/ID.
- pc2_output  in  XLEN  pc of ir2.
- r1_value  in  XLEN  regfile read for ir2[19:15].
- r2_value  in  XLEN  regfile read for ir2[24:20].
- wb_valid  in  1  writeback active.
- wb_rd  in  5  writeback destination.
- z5_output  in  XLEN  writeback data.
- ex_load  in  1  instruction in EX is a load.
- ex_rd  in  5  destination of the instruction in EX.
- out_valid  out  1  ID/EX register holds a real instruction.
- out_ready  in  1  execute accepts.
- ir3, pc3, x3, y3, md3, br_target  out  32/XLEN  registered ID/EX contents.
- illegal  out  1  registered; opcode not in the supported set.
- stall_cnt  out  CNT_W  saturating count of hazard cycles.

Behaviour:
- Reset (async) values:
  - out_valid=0, ir3=NOP_INSTR, illegal=0, stall_cnt=0.
  - pc3, x3, y3, md3 and br_target are 0.
- Latency is one cycle: accepted on edge N, visible after edge N.
- Definitions:
  - adv = !out_valid || out_ready.
  - haz = in_valid && ex_load && ex_rd!=0 && ((use_rs1 && rs1==ex_rd) || (use_rs2 && rs2==ex_rd)).
  - in_ready = flush || (adv && !haz).
- Edge priority:
  1. flush: out_valid<=0, ir3<=NOP_INSTR; any input is consumed and discarded.
  2. adv && haz: bubble (out_valid<=0, ir3<=NOP_INSTR); input held; stall_cnt++.
  3. adv && in_valid: load all outputs; out_valid<=1.
  4. adv && !in_valid: out_valid<=0, ir3<=NOP_INSTR.
  5. !adv: hold every output register.
- stall_cnt saturates at all-ones and never wraps.
- Operand forwarding:
  - rsX==0 gives 0.
  - Else if FWD_EN && wb_valid && wb_rd==rsX, gives z5_output.
  - Else gives rX_value.
- Opcode decode (ir2[6:0]):
  - OP 51: x=rs1f, y=rs2f.
  - OP-IMM 19: x=rs1f, y=I-imm.
  - LOAD 3: x=rs1f, y=I-imm.
  - JALR 103: x=pc, y=4, br_target=(rs1f+I-imm)&~1.
  - AUIPC 23: x=pc, y=U-imm.
  - LUI 55: x=0, y=U-imm.
  - STORE 35: x=rs1f, y=S-imm, md=rs2f.
  - BRANCH 99: x=rs1f, y=rs2f, br_target=pc+B-imm.
  - JAL 111: x=pc, y=4, br_target=pc+J-imm.
  - Any other opcode: illegal=1; operands as OP.
- Register usage and unused fields:
  - use_rs1 is true for every opcode except LUI, AUIPC and JAL.
  - use_rs2 is true for OP, STORE and BRANCH only.
  - md3 = rs2f for all opcodes.
  - br_target = pc+I-imm for opcodes without a target.
- Immediates are sign-extended to XLEN from ir2[31].
- U-imm = {ir2[31:12],12'b0} sign-extended.
- All adds are modulo 2^XLEN (pc wrap-around permitted, no flag).
- Hazard persists as long as the condition holds; one bubble per advancing cycle.
- Reset asserted mid-stall clears all state immediately; in_ready follows the combinational definition.

Decomposition:
- Package decode_pkg:
  - opcode localparams.
  - imm_type enum (I, S, B, U, J).
  - NOP_INSTR default.
- Sub-module imm_gen_x (combinational):
  - inputs: ir, imm_type.
  - output: XLEN immediate.
  - one instance.

Test Plan:
- Reset: assert reset mid-cycle → out_valid=0, ir3=32'h13 and stall_cnt=0 before the next edge.
- OP-IMM: addi x5,x1,-1 (ir2=32'hFFF08293), r1_value=10, out_ready=1 → next cycle x3=10, y3=32'hFFFFFFFF, out_valid=1.
- Forwarding:
  - add x3,x1,x2 with wb_valid=1, wb_rd=2, z5=99, r2_value=7 → y3=99.
  - Same with FWD_EN=0 → y3=7.
  - With rs=0 → operand 0.
- Load-use:
  - ex_load=1, ex_rd=1, ir2 uses x1 → in_ready=0, bubble (out_valid=0), stall_cnt=1.
  - Drop ex_load → instruction issues next edge.
- Branch and JAL:
  - beq at pc2=32'h100 with B-imm=-8 → br_target=32'hF8.
  - JAL at pc 32'hFFFFFFFC with imm=8 → br_target=4 (wrap), y3=4.
- Backpressure and flush:
  - out_ready=0 with out_valid=1 → outputs held 3 cycles, in_ready=0.
  - flush=1 → out_valid=0, ir3=NOP, in_ready=1.
